bp_fifo: RTL and testbench

BP_FIFO -- requirements
Module: bpFifo

---
 rtl/bp_fifo_pkg.sv | 11 +
 rtl/bp_fifo.sv | 96 +++++++++
 tb/tb_bp_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fifo_pkg.sv
// Shared byte-pipe definitions for the bp_fifo block.
//   BYTE_W : width of one bytepipe data beat
//   NENT_W : width of the zero-extended occupancy output
package bp_fifo_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NENT_W = 8;

    typedef logic [BYTE_W-1:0] bp_byte_t;

endpackage

// File: rtl/bp_fifo.sv
// bp_fifo: byte FIFO between two valid/ready bytepipes.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_cg              : clock-gate enable; 0 freezes push/pop state
//   i_flush           : synchronous discard of all stored bytes (ignores i_cg)
//   i_bp_data/valid   : upstream byte and valid; o_bp_ready back upstream
//   o_bp_data/valid   : downstream byte and valid; i_bp_ready from downstream
//   o_nEntries        : current occupancy, zero-extended to 8 bits
// Ready/valid are decoded from the registered occupancy only, so there is
// no combinational path from either handshake input to the other side.
module bp_fifo
    import bp_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cg,
    input  logic              i_flush,
    input  logic [BYTE_W-1:0] i_bp_data,
    input  logic              i_bp_valid,
    output logic              o_bp_ready,
    output logic [BYTE_W-1:0] o_bp_data,
    output logic              o_bp_valid,
    input  logic              i_bp_ready,
    output logic [NENT_W-1:0] o_nEntries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bp_byte_t         mem_q [DEPTH];

    logic full, empty, push, pop;

    // Pointer increment with explicit wrap, valid for non-power-of-2 DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full       = (cnt_q == CNT_FULL);
    assign empty      = (cnt_q == '0);
    assign o_bp_ready = !full;
    assign o_bp_valid = !empty;
    assign o_bp_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign o_nEntries = NENT_W'(cnt_q);

    assign push = i_cg && i_bp_valid && !full  && !i_flush;
    assign pop  = i_cg && i_bp_ready && !empty && !i_flush;

    // Next pointer/occupancy; flush wins over any handshake.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state; reset has priority over flush and clock gate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset: it is masked to zero on the output while empty.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem_q[wr_ptr_q] <= i_bp_data;
        end
    end

endmodule

// File: tb/tb_bp_fifo.sv
// Self-checking bench for bp_fifo: five instances (DEPTH 4,5,2,63,127) share
// one stimulus stream; a queue-style model per instance is checked every cycle,
// and directed phases add hand-computed literal expectations.
module tb_bp_fifo;

    localparam int N = 5;

    function automatic int unsigned dep(input int g);
        case (g)
            0:       return 4;
            1:       return 5;
            2:       return 2;
            3:       return 63;
            default: return 127;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cg, flush, bvalid, bready;
    logic [7:0] bdata;
    logic       o_ready [N];
    logic       o_valid [N];
    logic [7:0] o_data  [N];
    logic [7:0] o_nent  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        bp_fifo #(.DEPTH(dep(g))) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_cg       (cg),
            .i_flush    (flush),
            .i_bp_data  (bdata),
            .i_bp_valid (bvalid),
            .o_bp_ready (o_ready[g]),
            .o_bp_data  (o_data[g]),
            .o_bp_valid (o_valid[g]),
            .i_bp_ready (bready),
            .o_nEntries (o_nent[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Model: per-instance FIFO as a ring of 256 with free-running head/tail.
    logic [7:0] mbuf [N][256];
    logic [7:0] mhd  [N];
    logic [7:0] mtl  [N];
    logic [7:0] out5 [$];

    function automatic logic [7:0] mcnt(input int g);
        return mtl[g] - mhd[g];
    endfunction

    task automatic chk(input string name, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, g, act, exp);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < N; g++) begin
            logic [7:0] c;
            c = mcnt(g);
            chk("valid", g, int'(o_valid[g]), int'(c != 8'd0));
            chk("ready", g, int'(o_ready[g]), int'(32'(c) < dep(g)));
            chk("data",  g, int'(o_data[g]),  (c != 8'd0) ? int'(mbuf[g][mhd[g]]) : 0);
            chk("nent",  g, int'(o_nent[g]),  int'(c));
        end
    endtask

    task automatic model_update();
        for (int g = 0; g < N; g++) begin
            logic [7:0] c;
            logic       do_push, do_pop;
            c = mcnt(g);
            if (rst || flush) begin
                mtl[g] = mhd[g];
            end else if (cg) begin
                do_push = bvalid && (32'(c) < dep(g));
                do_pop  = bready && (c != 8'd0);
                if (do_pop) begin
                    if (g == 1) out5.push_back(mbuf[g][mhd[g]]);
                    mhd[g] = mhd[g] + 8'd1;
                end
                if (do_push) begin
                    mbuf[g][mtl[g]] = bdata;
                    mtl[g] = mtl[g] + 8'd1;
                end
            end
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model.
    task automatic cyc(input logic r, input logic c, input logic f,
                       input logic v, input logic [7:0] d, input logic rd);
        rst = r; cg = c; flush = f; bvalid = v; bdata = d; bready = rd;
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        int ncyc;
        logic v, rd, acc;

        for (int g = 0; g < N; g++) begin
            mhd[g] = 8'd0;
            mtl[g] = 8'd0;
        end
        rst = 1'b1; cg = 1'b0; flush = 1'b1; bvalid = 1'b1; bdata = 8'hFF; bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(1, 0, 1, 1, 8'hEE, 1);

        // Reset state
        chk("rst_valid", 0, int'(o_valid[0]), 0);
        chk("rst_ready", 0, int'(o_ready[0]), 1);
        chk("rst_data",  0, int'(o_data[0]),  0);
        chk("rst_nent",  0, int'(o_nent[0]),  0);

        // Fill DEPTH=4 with downstream stalled; 5th byte must be held off
        cyc(0, 1, 0, 1, 8'h11, 0);
        chk("lat_valid", 0, int'(o_valid[0]), 1);
        chk("lat_data",  0, int'(o_data[0]),  'h11);
        cyc(0, 1, 0, 1, 8'h22, 0);
        cyc(0, 1, 0, 1, 8'h33, 0);
        cyc(0, 1, 0, 1, 8'h44, 0);
        chk("full_nent",  0, int'(o_nent[0]),  4);
        chk("full_ready", 0, int'(o_ready[0]), 0);
        chk("d2_nent",    2, int'(o_nent[2]),  2);
        cyc(0, 1, 0, 1, 8'h55, 0);
        chk("held_nent", 0, int'(o_nent[0]), 4);
        chk("held_data", 0, int'(o_data[0]), 'h11);

        // Full + pop + valid: one pop, no push; next cycle accepts 0x55
        cyc(0, 1, 0, 1, 8'h55, 1);
        chk("fullpop_nent", 0, int'(o_nent[0]), 3);
        chk("fullpop_data", 0, int'(o_data[0]), 'h22);
        cyc(0, 1, 0, 1, 8'h55, 0);
        chk("refill_nent", 0, int'(o_nent[0]), 4);

        // Two entries, simultaneous push and pop
        cyc(0, 1, 1, 0, 8'h00, 0);
        cyc(0, 1, 0, 1, 8'hAA, 0);
        cyc(0, 1, 0, 1, 8'hBB, 0);
        cyc(0, 1, 0, 1, 8'hCC, 1);
        chk("pp_nent", 0, int'(o_nent[0]), 2);
        chk("pp_data", 0, int'(o_data[0]), 'hBB);
        cyc(0, 1, 0, 0, 8'h00, 1);
        chk("pp_next", 0, int'(o_data[0]), 'hCC);
        cyc(0, 1, 0, 0, 8'h00, 1);
        chk("pp_empty_data",  0, int'(o_data[0]),  0);
        chk("pp_empty_valid", 0, int'(o_valid[0]), 0);

        // Flush while clock gate is off
        cyc(0, 1, 0, 1, 8'h01, 0);
        cyc(0, 1, 0, 1, 8'h02, 0);
        cyc(0, 1, 0, 1, 8'h03, 0);
        chk("pre_flush_nent", 0, int'(o_nent[0]), 3);
        cyc(0, 0, 1, 1, 8'h04, 1);
        chk("flush_valid", 0, int'(o_valid[0]), 0);
        chk("flush_data",  0, int'(o_data[0]),  0);
        chk("flush_nent",  0, int'(o_nent[0]),  0);
        chk("flush_ready", 0, int'(o_ready[0]), 1);

        // Clock gate off freezes everything
        cyc(0, 1, 0, 1, 8'h05, 0);
        cyc(0, 1, 0, 1, 8'h06, 0);
        repeat (3) cyc(0, 0, 0, 1, 8'h07, 1);
        chk("cg_nent", 0, int'(o_nent[0]), 2);
        chk("cg_data", 0, int'(o_data[0]), 'h05);

        // DEPTH=5 ordered stream of 0x00..0x0B with random stalls
        cyc(0, 1, 1, 0, 8'h00, 0);
        out5.delete();
        nxt = 0;
        ncyc = 0;
        while (out5.size() < 12 && ncyc < 400) begin
            v   = (nxt < 12) && ($urandom_range(3) != 0);
            rd  = ($urandom_range(2) != 0);
            acc = v && (mcnt(1) < 8'd5);
            cyc(0, 1, 0, v, 8'(nxt), rd);
            if (acc) nxt++;
            ncyc++;
        end
        chk("seq_len", 1, out5.size(), 12);
        for (int i = 0; i < out5.size(); i++) chk("seq", 1, int'(out5[i]), i);

        // Random traffic with a reset pulse mid-stream
        cyc(0, 1, 1, 0, 8'h00, 0);
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                cyc(1, 1'($urandom_range(1)), 0, 1, 8'($urandom), 1);
                for (int g = 0; g < N; g++) begin
                    chk("mid_rst_valid", g, int'(o_valid[g]), 0);
                    chk("mid_rst_ready", g, int'(o_ready[g]), 1);
                    chk("mid_rst_data",  g, int'(o_data[g]),  0);
                    chk("mid_rst_nent",  g, int'(o_nent[g]),  0);
                end
                repeat (4) cyc(0, 1, 0, 0, 8'h00, 1);
            end else if (k >= 500 && k < 900) begin
                // Heavier upstream pressure so the deep instances fill up
                cyc(0, 1'($urandom_range(99) != 0), 0, 1'($urandom_range(3) != 0),
                    8'($urandom), 1'($urandom_range(3) == 0));
            end else begin
                cyc(0, 1'($urandom_range(99) != 0), 0, 1'($urandom_range(4) == 0),
                    8'($urandom), 1'($urandom_range(5) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
